pipe_trace_buffer: RTL and testbench

- Synthesizable, parametrised pipeline trace monitor that replaces per-cycle $display debugging of the pipeline busses.
- Samples PC/instruction/valid from NUM_CH pipeline stages into a DEPTH-entry circular buffer.
- Stops on a PC-match trigger plus a programmable post-trigger count, then drains the captured history oldest-first through a valid/ready port.
- Sits beside the pipeline at core top, observing stage busses only, never driving them.

---
 rtl/pipe_trace_buffer_pkg.sv | 23 ++
 rtl/pipe_trace_buffer_if.sv | 34 +++
 rtl/pipe_trace_buffer_trace_ring.sv | 69 ++++++
 rtl/pipe_trace_buffer.sv | 156 +++++++++++++++
 tb/tb_pipe_trace_buffer.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_trace_buffer_pkg.sv
// Shared types and constants for the pipeline trace buffer.
//   trace_state_t : capture FSM state, also driven out on state_o
//   TRACE_DEFAULT_* : default geometry used by the interface and modules
//   sel_width()   : width of a channel-select field (at least one bit)
package pipe_trace_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } trace_state_t;

  localparam int TRACE_DEFAULT_DEPTH   = 16;
  localparam int TRACE_DEFAULT_CH      = 4;
  localparam int TRACE_DEFAULT_XLEN    = 32;
  localparam int TRACE_DEFAULT_STAMP_W = 32;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_if.sv
// Readout port of the trace buffer.
//   master : the trace buffer (drives the entry fields and rd_valid_o)
//   slave  : the consumer (drives rd_ready_i)
// Handshake: an entry transfers on every rising clk edge where
// rd_valid_o && rd_ready_i. rd_valid_o never depends on rd_ready_i, and
// while rd_valid_o is high without rd_ready_i the entry fields hold steady.
// When rd_valid_o is low all entry fields read as zero.
interface pipe_trace_buffer_if
  import pipe_trace_buffer_pkg::*;
#(
  parameter int NUM_CH  = TRACE_DEFAULT_CH,
  parameter int XLEN    = TRACE_DEFAULT_XLEN,
  parameter int STAMP_W = TRACE_DEFAULT_STAMP_W
) ();

  logic                     rd_valid_o;
  logic                     rd_ready_i;
  logic [STAMP_W-1:0]       rd_stamp_o;
  logic [NUM_CH-1:0]        rd_mask_o;
  logic [NUM_CH*XLEN-1:0]   rd_pc_o;
  logic [NUM_CH*XLEN-1:0]   rd_instr_o;
  logic                     rd_trig_o;

  modport master (
    output rd_valid_o, rd_stamp_o, rd_mask_o, rd_pc_o, rd_instr_o, rd_trig_o,
    input  rd_ready_i
  );

  modport slave (
    input  rd_valid_o, rd_stamp_o, rd_mask_o, rd_pc_o, rd_instr_o, rd_trig_o,
    output rd_ready_i
  );

endinterface

// File: rtl/pipe_trace_buffer_trace_ring.sv
// trace_ring: DEPTH-entry circular store of W-bit trace entries.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : empty the ring (pointers, count, overflow) on this edge
//   wr_en     : append wr_data; when full the oldest entry is overwritten
//   rd_en     : drop the oldest entry (ignored when empty)
//   rd_data   : oldest entry, combinational
//   count     : occupied entries, 0..DEPTH
//   overflow  : sticky, set when a write overwrote an entry since clear
// Storage itself is not reset; only the bookkeeping is.
module trace_ring
  import pipe_trace_buffer_pkg::*;
#(
  parameter int  DEPTH = TRACE_DEFAULT_DEPTH,
  parameter int  W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   count,
  output logic          overflow
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;

  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (full) begin
        // Full: the write lands on the oldest slot, so the read side
        // moves with it and the occupancy stays at DEPTH.
        rd_ptr   <= rd_ptr + AW'(1);
        overflow <= 1'b1;
      end else begin
        count <= count + (AW+1)'(1);
      end
    end else if (rd_en && (count != '0)) begin
      rd_ptr <= rd_ptr + AW'(1);
      count  <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: passive pipeline trace monitor.
// Samples valid/PC/instruction of NUM_CH pipeline stages into a DEPTH-entry
// ring each cycle any stage is valid, stops post_cnt_i entries after the
// trigger entry (PC match on channel trig_ch_i), then drains the history
// oldest-first through the rd interface.
//   clk, rst      : core clock, asynchronous active-high reset
//   ch_valid_i    : per-stage valid
//   ch_pc_i       : per-stage PC, channel k at [k*XLEN +: XLEN]
//   ch_instr_i    : per-stage instruction, same packing
//   arm_i         : start/restart capture (clears the ring)
//   trig_pc_i     : trigger PC
//   trig_ch_i     : channel compared against trig_pc_i
//   post_cnt_i    : entries captured after the trigger entry
//   rd            : readout port (valid/ready, see pipe_trace_buffer_if)
//   state_o       : trace_state_t
//   count_o       : occupied entries
//   overflow_o    : sticky, an entry was overwritten since arm
module pipe_trace_buffer
  import pipe_trace_buffer_pkg::*;
#(
  parameter int  DEPTH   = TRACE_DEFAULT_DEPTH,
  parameter int  NUM_CH  = TRACE_DEFAULT_CH,
  parameter int  XLEN    = TRACE_DEFAULT_XLEN,
  parameter int  STAMP_W = TRACE_DEFAULT_STAMP_W,
  localparam int AW      = $clog2(DEPTH),
  localparam int TCW     = sel_width(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      ch_valid_i,
  input  logic [NUM_CH*XLEN-1:0] ch_pc_i,
  input  logic [NUM_CH*XLEN-1:0] ch_instr_i,
  input  logic                   arm_i,
  input  logic [XLEN-1:0]        trig_pc_i,
  input  logic [TCW-1:0]         trig_ch_i,
  input  logic [AW-1:0]          post_cnt_i,
  pipe_trace_buffer_if.master    rd,
  output trace_state_t           state_o,
  output logic [AW:0]            count_o,
  output logic                   overflow_o
);

  // Entry layout, MSB to LSB: stamp | mask | pcs | instrs | trig
  localparam int BUS_W = NUM_CH * XLEN;
  localparam int EW    = STAMP_W + NUM_CH + 2 * BUS_W + 1;

  trace_state_t       state;
  logic [AW-1:0]      post_ctr;
  logic [STAMP_W-1:0] stamp;

  logic               trig_hit;
  logic               capture;
  logic               pop;
  logic               rd_avail;
  logic [EW-1:0]      wr_entry;
  logic [EW-1:0]      rd_entry;
  logic [EW-1:0]      rd_shown;
  logic [AW:0]        ring_count;
  logic               ring_overflow;

  // Out-of-range trig_ch_i matches no channel, so the trigger never fires.
  always_comb begin
    trig_hit = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if ((trig_ch_i == TCW'(k)) && ch_valid_i[k] &&
          (ch_pc_i[k*XLEN +: XLEN] == trig_pc_i)) begin
        trig_hit = 1'b1;
      end
    end
  end

  // arm_i has priority in every state: that edge only clears the ring.
  assign capture  = ((state == ARMED) || (state == POST)) && !arm_i && (|ch_valid_i);
  assign rd_avail = (state == FROZEN) && (ring_count != '0);
  assign pop      = rd_avail && rd.rd_ready_i && !arm_i;
  assign wr_entry = {stamp, ch_valid_i, ch_pc_i, ch_instr_i,
                     capture && (state == ARMED) && trig_hit};

  trace_ring #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .clear    (arm_i),
    .wr_en    (capture),
    .wr_data  (wr_entry),
    .rd_en    (pop),
    .rd_data  (rd_entry),
    .count    (ring_count),
    .overflow (ring_overflow)
  );

  // Free-running cycle stamp; wraps naturally at 2^STAMP_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamp <= '0;
    end else begin
      stamp <= stamp + STAMP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      post_ctr <= '0;
    end else if (arm_i) begin
      state    <= ARMED;
      post_ctr <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        ARMED: begin
          if (capture && trig_hit) begin
            post_ctr <= post_cnt_i;
            state    <= (post_cnt_i == '0) ? FROZEN : POST;
          end
        end
        POST: begin
          // Bubble cycles are not written and leave the counter alone.
          if (capture) begin
            post_ctr <= post_ctr - AW'(1);
            if (post_ctr == AW'(1)) begin
              state <= FROZEN;
            end
          end
        end
        FROZEN: begin
          if (pop && (ring_count == (AW+1)'(1))) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outside a valid readout the entry fields are forced to zero so stale
  // storage never leaks onto the port.
  assign rd_shown      = rd_avail ? rd_entry : '0;
  assign rd.rd_valid_o = rd_avail;
  assign rd.rd_trig_o  = rd_shown[0];
  assign rd.rd_instr_o = rd_shown[1 +: BUS_W];
  assign rd.rd_pc_o    = rd_shown[1 + BUS_W +: BUS_W];
  assign rd.rd_mask_o  = rd_shown[1 + 2*BUS_W +: NUM_CH];
  assign rd.rd_stamp_o = rd_shown[EW-1 -: STAMP_W];

  assign state_o    = state;
  assign count_o    = ring_count;
  assign overflow_o = ring_overflow;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Testbench for pipe_trace_buffer (DEPTH=8, NUM_CH=2).
// A queue-based reference model tracks what the buffer must hold; a
// negedge compare process checks every DUT output against it each cycle.
// Directed scenarios add literal expectations; a random phase follows.
module tb_pipe_trace_buffer;

  localparam int DEPTH   = 8;
  localparam int NUM_CH  = 2;
  localparam int XLEN    = 32;
  localparam int STAMP_W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ch_valid_i;
  logic [63:0] ch_pc_i;
  logic [63:0] ch_instr_i;
  logic        arm_i;
  logic [31:0] trig_pc_i;
  logic [0:0]  trig_ch_i;
  logic [2:0]  post_cnt_i;
  logic [1:0]  state_o;
  logic [3:0]  count_o;
  logic        overflow_o;

  always #5 clk = ~clk;

  pipe_trace_buffer_if #(.NUM_CH(NUM_CH), .XLEN(XLEN), .STAMP_W(STAMP_W)) rd ();

  pipe_trace_buffer #(
    .DEPTH(DEPTH), .NUM_CH(NUM_CH), .XLEN(XLEN), .STAMP_W(STAMP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_valid_i (ch_valid_i),
    .ch_pc_i    (ch_pc_i),
    .ch_instr_i (ch_instr_i),
    .arm_i      (arm_i),
    .trig_pc_i  (trig_pc_i),
    .trig_ch_i  (trig_ch_i),
    .post_cnt_i (post_cnt_i),
    .rd         (rd),
    .state_o    (state_o),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] stamp;
    logic [1:0]  mask;
    logic [63:0] pc;
    logic [63:0] instr;
    logic        trig;
  } ent_t;

  ent_t        mq[$];
  int          m_state;   // 0 idle, 1 armed, 2 post, 3 frozen
  int          m_post;
  logic        m_ovf;
  logic [31:0] m_stamp;
  ent_t        m_e;
  logic        m_hit;
  int          m_tc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_state = 0;
      m_post  = 0;
      m_ovf   = 1'b0;
      m_stamp = '0;
    end else begin
      m_tc  = int'(trig_ch_i);
      m_hit = (m_tc < NUM_CH) && ch_valid_i[m_tc] && (ch_pc_i[m_tc*32 +: 32] == trig_pc_i);
      if (arm_i) begin
        mq.delete();
        m_ovf   = 1'b0;
        m_post  = 0;
        m_state = 1;
      end else if ((m_state == 1 || m_state == 2) && (ch_valid_i != 2'b00)) begin
        m_e.stamp = m_stamp;
        m_e.mask  = ch_valid_i;
        m_e.pc    = ch_pc_i;
        m_e.instr = ch_instr_i;
        m_e.trig  = (m_state == 1) && m_hit;
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          m_ovf = 1'b1;
        end
        mq.push_back(m_e);
        if (m_state == 1) begin
          if (m_hit) begin
            if (post_cnt_i == 3'd0) m_state = 3;
            else begin
              m_state = 2;
              m_post  = int'(post_cnt_i);
            end
          end
        end else begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
      end else if (m_state == 3 && mq.size() != 0 && rd.rd_ready_i) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_state = 0;
      end
      m_stamp = m_stamp + 32'd1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic exp_valid;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      exp_valid = (m_state == 3) && (mq.size() != 0);
      check("rd_valid", rd.rd_valid_o, exp_valid);
      check("state", state_o, m_state);
      check("count", count_o, mq.size());
      check("overflow", overflow_o, m_ovf);
      if (exp_valid) begin
        check("rd_stamp", rd.rd_stamp_o, mq[0].stamp);
        check("rd_mask", rd.rd_mask_o, mq[0].mask);
        check("rd_pc", rd.rd_pc_o, mq[0].pc);
        check("rd_instr", rd.rd_instr_o, mq[0].instr);
        check("rd_trig", rd.rd_trig_o, mq[0].trig);
      end else begin
        check("rd_idle_pc", rd.rd_pc_o, 0);
        check("rd_idle_instr", rd.rd_instr_o, 0);
        check("rd_idle_misc", {rd.rd_stamp_o, rd.rd_mask_o, rd.rd_trig_o}, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [31:0] got_pc[$];
  logic [31:0] got_stamp[$];
  logic        got_trig[$];
  logic [31:0] next_pc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [31:0] tpc, input logic tch, input logic [2:0] post);
    trig_pc_i  = tpc;
    trig_ch_i  = tch;
    post_cnt_i = post;
    ch_valid_i = 2'b00;
    arm_i      = 1'b1;
    tick();
    arm_i      = 1'b0;
  endtask

  // ch0 carries PCs start, start+4, ...; ch1 sits far away so only ch0 triggers.
  task automatic feed(input logic [31:0] start, input int max, output logic [31:0] nxt);
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < max; i++) begin
      ch_valid_i = {1'($urandom_range(0, 1)), 1'b1};
      ch_pc_i    = {pc + 32'h1000, pc};
      ch_instr_i = {$urandom, $urandom};
      tick();
      pc = pc + 32'd4;
      if (state_o != 2'd1 && state_o != 2'd2) break;
    end
    ch_valid_i = 2'b00;
    nxt = pc;
  endtask

  task automatic drain(input bit toggle);
    logic [31:0] hold_stamp;
    logic [63:0] hold_pc;
    got_pc.delete();
    got_stamp.delete();
    got_trig.delete();
    for (int i = 0; i < 40 && rd.rd_valid_o; i++) begin
      if (toggle && (i % 2 == 1)) begin
        rd.rd_ready_i = 1'b0;
        hold_stamp = rd.rd_stamp_o;
        hold_pc    = rd.rd_pc_o;
        tick();
        check("hold_stamp", rd.rd_stamp_o, hold_stamp);
        check("hold_pc", rd.rd_pc_o, hold_pc);
        check("hold_count", count_o, DEPTH - got_pc.size());
      end else begin
        rd.rd_ready_i = 1'b1;
        got_pc.push_back(rd.rd_pc_o[31:0]);
        got_stamp.push_back(rd.rd_stamp_o);
        got_trig.push_back(rd.rd_trig_o);
        tick();
      end
    end
    rd.rd_ready_i = 1'b0;
  endtask

  task automatic check_drain(input string tag, input logic [31:0] base, input int trig_idx,
                             input int gap_idx);
    check({tag, "_n"}, got_pc.size(), DEPTH);
    for (int i = 0; i < got_pc.size(); i++) begin
      check({tag, "_pc"}, got_pc[i], base + 32'(4 * i));
      check({tag, "_trig"}, got_trig[i], (i == trig_idx));
      if (i > 0) check({tag, "_stamp_step"}, got_stamp[i] - got_stamp[i-1], (i == gap_idx) ? 6 : 1);
    end
    check({tag, "_idle"}, state_o, 0);
    check({tag, "_empty"}, count_o, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst           = 1'b1;
    ch_valid_i    = '0;
    ch_pc_i       = '0;
    ch_instr_i    = '0;
    arm_i         = 1'b0;
    trig_pc_i     = '0;
    trig_ch_i     = '0;
    post_cnt_i    = '0;
    rd.rd_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state_o, 0);
    check("rst_count", count_o, 0);
    check("rst_valid", rd.rd_valid_o, 0);
    rst = 1'b0;
    tick();
    check("post_rst_overflow", overflow_o, 0);

    // 1: trigger 0x10, post 3 -> frozen after 0x1C, 8 entries from 0x0
    do_arm(32'h10, 1'b0, 3'd3);
    feed(32'h0, 40, next_pc);
    check("t1_frozen", state_o, 3);
    check("t1_last_pc", next_pc, 32'h20);
    check("t1_count", count_o, 8);
    check("t1_oldest", rd.rd_pc_o[31:0], 32'h0);
    check("t1_ovf", overflow_o, 0);
    drain(1'b0);
    check_drain("t1", 32'h0, 4, -1);

    // 2: trigger late -> overwrite, oldest kept is 0x34
    do_arm(32'h44, 1'b0, 3'd3);
    feed(32'h0, 40, next_pc);
    check("t2_frozen", state_o, 3);
    check("t2_ovf", overflow_o, 1);
    check("t2_count", count_o, 8);
    drain(1'b0);
    check_drain("t2", 32'h34, 4, -1);

    // 3+4: bubbles during POST, then drain with ready toggling
    do_arm(32'h10, 1'b0, 3'd3);
    feed(32'h0, 5, next_pc);
    repeat (5) tick();
    check("t3_still_post", state_o, 2);
    check("t3_count", count_o, 5);
    feed(32'h14, 40, next_pc);
    check("t3_frozen", state_o, 3);
    check("t3_last_pc", next_pc, 32'h20);
    drain(1'b1);
    check_drain("t3", 32'h0, 4, 5);

    // 5: arm while frozen with 5 entries
    do_arm(32'h8, 1'b0, 3'd2);
    feed(32'h0, 40, next_pc);
    check("t5_frozen", state_o, 3);
    check("t5_count5", count_o, 5);
    do_arm(32'h8, 1'b0, 3'd2);
    check("t5_rearm_state", state_o, 1);
    check("t5_rearm_count", count_o, 0);
    check("t5_rearm_valid", rd.rd_valid_o, 0);
    // arm and a matching trigger in the same cycle: arm wins
    arm_i      = 1'b1;
    ch_valid_i = 2'b01;
    ch_pc_i    = {32'h1000, 32'h8};
    tick();
    arm_i      = 1'b0;
    ch_valid_i = 2'b00;
    check("t5_armtrig_state", state_o, 1);
    check("t5_armtrig_count", count_o, 0);

    // 6: reset during POST, then a normal capture
    do_arm(32'h10, 1'b0, 3'd3);
    feed(32'h0, 6, next_pc);
    check("t6_post", state_o, 2);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_state", state_o, 0);
    check("t6_rst_count", count_o, 0);
    check("t6_rst_valid", rd.rd_valid_o, 0);
    check("t6_rst_ovf", overflow_o, 0);
    tick();
    rst = 1'b0;
    tick();
    do_arm(32'h10, 1'b0, 3'd3);
    feed(32'h0, 40, next_pc);
    check("t6_frozen", state_o, 3);
    drain(1'b0);
    check_drain("t6", 32'h0, 4, -1);

    // 7: random traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      if ((state_o == 2'd0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) < 2) begin
        arm_i      = 1'b1;
        trig_pc_i  = 32'($urandom_range(0, 15)) << 2;
        trig_ch_i  = 1'($urandom_range(0, 1));
        post_cnt_i = 3'($urandom_range(0, 7));
      end else begin
        arm_i = 1'b0;
      end
      ch_valid_i    = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      ch_pc_i       = {32'($urandom_range(0, 15)) << 2, 32'($urandom_range(0, 15)) << 2};
      ch_instr_i    = {$urandom, $urandom};
      rd.rd_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    arm_i         = 1'b0;
    ch_valid_i    = 2'b00;
    rd.rd_ready_i = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
